// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - issue-stage RAW hazard detector with bubble insertion
//
// Purpose:
//   Sits between fetch and decode of the 8-bit 5-stage pipeline. Keeps a
//   3-entry history of issued slots (h1 newest .. h3 oldest) and stalls an
//   incoming instruction with noop bubbles until every producer it depends
//   on is far enough back in the issue stream.
//
// Optional feature:
//   HAZARD_FWD_EN - assume an EX/MEM forwarding path; each producer gap is
//                   reduced by one (never below one).
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   fetch presents in_instr
//   in_instr   [7:6] opcode (11 lw, 10 sw, 01 add, 00 noop), [5:3] A, [2:0] B
//   in_ready   instruction consumed this cycle (combinational)
//   out_ready  decode accepts a slot this cycle
//   out_valid  out_instr holds a valid slot
//   out_instr  registered issued instruction, 8'h00 for bubble/empty slot
//   out_bubble current slot is a hazard bubble
//   stall_cnt  saturating count of hazard bubbles

module hazard_stall_unit #(
  parameter int LW_GAP  = 3,
  parameter int ADD_GAP = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_instr,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_instr,
  output logic             out_bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] OPC_NOOP = 2'b00;
  localparam logic [1:0] OPC_ADD  = 2'b01;
  localparam logic [1:0] OPC_SW   = 2'b10;
  localparam logic [1:0] OPC_LW   = 2'b11;

`ifdef HAZARD_FWD_EN
  localparam int LW_EFF  = (LW_GAP  > 1) ? LW_GAP  - 1 : 1;
  localparam int ADD_EFF = (ADD_GAP > 1) ? ADD_GAP - 1 : 1;
`else
  localparam int LW_EFF  = LW_GAP;
  localparam int ADD_EFF = ADD_GAP;
`endif

  // History entry k-1 holds the slot issued k advances ago.
  logic [2:0] r_h_dv;
  logic [2:0] r_h_dest [3];
  logic [1:0] r_h_opc  [3];

  logic [1:0] w_opc;
  logic [2:0] w_src_a;
  logic [2:0] w_src_b;
  logic       w_use_a;
  logic       w_use_b;
  logic       w_hit;
  logic       w_hazard;
  logic       w_accept;

  assign w_opc   = in_instr[7:6];
  assign w_src_a = in_instr[5:3];
  assign w_src_b = in_instr[2:0];

  // lw reads only B; add and sw read both A and B; noop reads nothing.
  assign w_use_a = (w_opc == OPC_ADD) || (w_opc == OPC_SW);
  assign w_use_b = (w_opc != OPC_NOOP);

  // A valid entry is always lw or add, so anything not lw takes the add gap.
  function automatic int eff_gap(input logic [1:0] opc);
    return (opc == OPC_LW) ? LW_EFF : ADD_EFF;
  endfunction

  // Any matching entry still inside its gap blocks issue; the instruction
  // therefore waits for the farthest-remaining producer.
  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (r_h_dv[k] && (r_h_dest[k] != 3'd0) &&
          ((w_use_a && (r_h_dest[k] == w_src_a)) ||
           (w_use_b && (r_h_dest[k] == w_src_b))) &&
          ((k + 1) < eff_gap(r_h_opc[k]))) begin
        w_hit = 1'b1;
      end
    end
  end

  assign w_hazard = in_valid & w_hit;
  assign w_accept = in_valid & ~w_hit;
  assign in_ready = out_ready & w_accept & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_instr  <= 8'h00;
      out_valid  <= 1'b0;
      out_bubble <= 1'b0;
      stall_cnt  <= '0;
      r_h_dv     <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        r_h_dest[k] <= 3'd0;
        r_h_opc[k]  <= OPC_NOOP;
      end
    end else if (out_ready) begin
      out_valid <= 1'b1;
      // Empty and bubble slots shift in too, so they count toward distance.
      r_h_dv[2]   <= r_h_dv[1];
      r_h_dv[1]   <= r_h_dv[0];
      r_h_dest[2] <= r_h_dest[1];
      r_h_dest[1] <= r_h_dest[0];
      r_h_opc[2]  <= r_h_opc[1];
      r_h_opc[1]  <= r_h_opc[0];
      r_h_dest[0] <= w_src_a;
      r_h_opc[0]  <= w_opc;
      if (w_accept) begin
        out_instr  <= in_instr;
        out_bubble <= 1'b0;
        r_h_dv[0]  <= (w_opc == OPC_LW) || (w_opc == OPC_ADD);
      end else if (w_hazard) begin
        out_instr  <= 8'h00;
        out_bubble <= 1'b1;
        r_h_dv[0]  <= 1'b0;
        if (stall_cnt != {CNT_W{1'b1}}) begin
          stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        out_instr  <= 8'h00;
        out_bubble <= 1'b0;
        r_h_dv[0]  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit

module tb_hazard_stall_unit;

`ifdef HAZARD_FWD_EN
  localparam int LWG  = 2;
  localparam int ADDG = 1;
`else
  localparam int LWG  = 3;
  localparam int ADDG = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_instr = 8'h00;
  logic       in_ready;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_instr;
  logic       out_bubble;
  logic [7:0] stall_cnt;

  hazard_stall_unit #(.LW_GAP(3), .ADD_GAP(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_bubble (out_bubble),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ins;
    logic       bub;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] exp_cnt = 8'h00;
  logic adv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every advance edge produces one slot that must match the queue head.
  always @(posedge clk) adv <= out_ready && !rst;

  always @(negedge clk) begin
    if (adv) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_slot: got instr %0h with empty scoreboard", out_instr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("slot_valid", out_valid, 1);
        chk("slot_instr", out_instr, e.ins);
        chk("slot_bubble", out_bubble, e.bub);
        chk("slot_cnt", stall_cnt, e.cnt);
      end
    end
  end

  // Drive one cycle; push the expected slot when this edge advances.
  task automatic step(input logic v, input logic [7:0] ins, input logic ordy, input logic r,
                      input logic exp_rdy, input logic [7:0] e_ins, input logic e_bub);
    exp_t e;
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    rst       = r;
    if (r) begin
      exp_cnt = 8'h00;
    end else if (ordy) begin
      if (e_bub && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      e.ins = e_ins;
      e.bub = e_bub;
      e.cnt = exp_cnt;
      q.push_back(e);
    end
    #1;
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ins, input int nb);
    for (int i = 0; i < nb; i++) step(1'b1, ins, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, ins, 1'b1, 1'b0, 1'b1, ins, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 8'h00);
    chk("rst_bubble", out_bubble, 0);
    chk("rst_cnt", stall_cnt, 0);
  endtask

  initial begin
    // lw r1,r2 -> add r3,r1
    do_reset();
    issue(8'hCA, 0);
    issue(8'h59, LWG - 1);
    idle();
    chk("lw_add_cnt", stall_cnt, LWG - 1);

    // add r1,r2 -> add r3,r1
    do_reset();
    issue(8'h4A, 0);
    issue(8'h59, ADDG - 1);
    idle();
    chk("add_add_cnt", stall_cnt, ADDG - 1);

    // independent stream and register-0 cases
    do_reset();
    issue(8'h4A, 0);
    issue(8'h9C, 0);
    issue(8'h42, 0);
    issue(8'h58, 0);
    idle();
    chk("nodep_cnt", stall_cnt, 0);

    // idle slot counts toward distance
    do_reset();
    issue(8'hCA, 0);
    idle();
    issue(8'h59, (LWG > 2) ? LWG - 2 : 0);
    chk("idle_gap_cnt", stall_cnt, (LWG > 2) ? LWG - 2 : 0);

    // out_ready dropped mid-stall
    do_reset();
    issue(8'hCA, 0);
    step(1'b1, 8'h59, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h59, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("frz_instr", out_instr, 8'h00);
      chk("frz_bubble", out_bubble, 1);
      chk("frz_cnt", stall_cnt, 1);
    end
    issue(8'h59, LWG - 2);
    chk("frz_final_cnt", stall_cnt, LWG - 1);

    // reset in the middle of a stall
    do_reset();
    issue(8'hCA, 0);
    step(1'b1, 8'h59, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h59, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_instr", out_instr, 8'h00);
    chk("midrst_cnt", stall_cnt, 0);
    issue(8'h59, 0);
    chk("midrst_after_cnt", stall_cnt, 0);

    // counter saturation
    do_reset();
    for (int i = 0; i < 300 / (LWG - 1) + 1; i++) begin
      issue(8'hCA, 0);
      issue(8'h59, LWG - 1);
    end
    chk("sat_cnt", stall_cnt, 255);

    idle();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
